// File: rtl/decode_stage_hs_if.sv
// Decode stage bus: upstream fetch handshake, writeback port, flush and the
// downstream ID/EX bundle with its handshake.
interface decode_stage_hs_if #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int NREGS = 32
);
  localparam int REGW = $clog2(NREGS);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            wb_en;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_alu_sub_sra;
  logic [REGW-1:0] out_rd;
  logic            out_rd_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_illegal;
  logic [XLEN-1:0] out_rs1_value;
  logic [XLEN-1:0] out_rs2_value;
  logic [XLEN-1:0] out_imm;

  // Environment side: fetch, writeback and execute.
  modport master (
    output flush, in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_alu_sub_sra, out_rd, out_rd_write, out_mem_read, out_mem_write,
           out_illegal, out_rs1_value, out_rs2_value, out_imm
  );

  // Decode stage side.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_alu_sub_sra, out_rd, out_rd_write, out_mem_read, out_mem_write,
           out_illegal, out_rs1_value, out_rs2_value, out_imm
  );
endinterface

// File: rtl/decode_stage_hs.sv
// RV32 decode stage: register file with writeback bypass, immediate
// generation, load-use interlock and a valid/ready ID/EX output register.
module decode_stage_hs #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int NREGS = 32
) (
  input logic             clk,
  input logic             reset,
  decode_stage_hs_if.slave bus
);
  localparam int REGW = $clog2(NREGS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            alu_sub_sra;
    logic [REGW-1:0] rd;
    logic            rd_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [XLEN-1:0] imm;
  } bundle_t;

  logic [XLEN-1:0] regs [NREGS];

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_f;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [REGW-1:0] rd_idx;
  logic [REGW-1:0] rs1_idx;
  logic [REGW-1:0] rs2_idx;

  logic is_r, is_iop, is_load, is_lui, is_branch, is_jal, is_store, known;
  logic use_rs1, use_rs2, use_rd, bad_reg, illegal;
  logic hazard, accept, out_valid_q;
  logic [31:0] imm32;

  bundle_t dec;
  bundle_t q;

  assign instr   = bus.in_instr;
  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign rd_f    = instr[11:7];
  assign rs1_f   = instr[19:15];
  assign rs2_f   = instr[24:20];
  assign rd_idx  = rd_f[REGW-1:0];
  assign rs1_idx = rs1_f[REGW-1:0];
  assign rs2_idx = rs2_f[REGW-1:0];

  assign is_r      = (opcode == OP_R);
  assign is_iop    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_lui    = (opcode == OP_LUI);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_store  = (opcode == OP_STORE);
  assign known     = is_r | is_iop | is_load | is_lui | is_branch | is_jal | is_store;

  assign use_rs1 = is_r | is_iop | is_load | is_store | is_branch;
  assign use_rs2 = is_r | is_store | is_branch;
  assign use_rd  = is_r | is_iop | is_load | is_lui | is_jal;

  // With 16 registers, bit 4 of any field that is actually used names a
  // register that does not exist.
  assign bad_reg = (NREGS == 16) &&
                   ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]));
  assign illegal = !known || bad_reg;

  // Immediate generation: pick the format by opcode, sign-extend afterwards.
  always_comb begin
    imm32 = '0;
    if (is_iop || is_load)
      imm32 = {{20{instr[31]}}, instr[31:20]};
    else if (is_store)
      imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_branch)
      imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (is_lui)
      imm32 = {instr[31:12], 12'b0};
    else if (is_jal)
      imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  // Decode the incoming instruction into the bundle the output register loads.
  always_comb begin
    dec          = '0;
    dec.pc       = bus.in_pc;
    dec.opcode   = opcode;
    dec.funct3   = funct3;
    if (is_r || (is_iop && (funct3 == 3'b001 || funct3 == 3'b101)))
      dec.funct7 = instr[31:25];
    if ((is_r && (funct3 == 3'b000 || funct3 == 3'b101)) || (is_iop && funct3 == 3'b101))
      dec.alu_sub_sra = instr[30];
    if (use_rd)
      dec.rd = rd_idx;
    dec.rd_write  = use_rd && (rd_f != 5'd0) && !illegal;
    dec.mem_read  = is_load && !illegal;
    dec.mem_write = is_store && !illegal;
    dec.illegal   = illegal;
    if (use_rs1 && rs1_idx != '0)
      dec.rs1_value = (bus.wb_en && bus.wb_rd == rs1_idx) ? bus.wb_data : regs[rs1_idx];
    if (use_rs2 && rs2_idx != '0)
      dec.rs2_value = (bus.wb_en && bus.wb_rd == rs2_idx) ? bus.wb_data : regs[rs2_idx];
    dec.imm = XLEN'($signed(imm32));
  end

  // Register file write port; x0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != '0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Load-use interlock: a load in the output register feeding this instruction.
  always_comb begin
    hazard = 1'b0;
    if (out_valid_q && q.mem_read && q.rd_write && bus.in_valid)
      hazard = (use_rs1 && rs1_idx == q.rd) || (use_rs2 && rs2_idx == q.rd);
  end

  assign bus.in_ready = !reset && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // ID/EX register: flush kills, accept loads, drained slot becomes a bubble,
  // a stalled bundle holds every field.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      q           <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      q           <= dec;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_pc          = q.pc;
  assign bus.out_opcode      = q.opcode;
  assign bus.out_funct3      = q.funct3;
  assign bus.out_funct7      = q.funct7;
  assign bus.out_alu_sub_sra = q.alu_sub_sra;
  assign bus.out_rd          = q.rd;
  assign bus.out_rd_write    = q.rd_write;
  assign bus.out_mem_read    = q.mem_read;
  assign bus.out_mem_write   = q.mem_write;
  assign bus.out_illegal     = q.illegal;
  assign bus.out_rs1_value   = q.rs1_value;
  assign bus.out_rs2_value   = q.rs2_value;
  assign bus.out_imm         = q.imm;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Testbench for decode_stage_hs: table of decoded instructions plus hand
// sequences for bypass, load-use, stall hold, flush and 16-register mode.
module tb_decode_stage_hs;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        sub_sra;
    logic [4:0]  rd;
    logic        rd_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bundle_t     exp;
  } vec_t;

  logic clk;
  logic reset;
  int checks = 0;
  int errors = 0;
  bundle_t sb[$];
  bundle_t mon_exp;

  decode_stage_hs_if #(.XLEN(32), .PC_W(32), .NREGS(32)) bus32 ();
  decode_stage_hs_if #(.XLEN(32), .PC_W(32), .NREGS(16)) bus16 ();

  decode_stage_hs #(.XLEN(32), .PC_W(32), .NREGS(32)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32.slave)
  );
  decode_stage_hs #(.XLEN(32), .PC_W(32), .NREGS(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bundle_t mk(logic [31:0] pc, logic [31:0] op, logic [31:0] f3,
                                 logic [31:0] f7, logic [31:0] sub, logic [31:0] rd,
                                 logic [31:0] rdw, logic [31:0] mr, logic [31:0] mw,
                                 logic [31:0] ill, logic [31:0] r1, logic [31:0] r2,
                                 logic [31:0] imm);
    bundle_t b;
    b.pc        = pc;
    b.opcode    = 7'(op);
    b.funct3    = 3'(f3);
    b.funct7    = 7'(f7);
    b.sub_sra   = 1'(sub);
    b.rd        = 5'(rd);
    b.rd_write  = 1'(rdw);
    b.mem_read  = 1'(mr);
    b.mem_write = 1'(mw);
    b.illegal   = 1'(ill);
    b.rs1_value = r1;
    b.rs2_value = r2;
    b.imm       = imm;
    return b;
  endfunction

  function automatic bundle_t getBundle();
    bundle_t b;
    b.pc        = bus32.out_pc;
    b.opcode    = bus32.out_opcode;
    b.funct3    = bus32.out_funct3;
    b.funct7    = bus32.out_funct7;
    b.sub_sra   = bus32.out_alu_sub_sra;
    b.rd        = bus32.out_rd;
    b.rd_write  = bus32.out_rd_write;
    b.mem_read  = bus32.out_mem_read;
    b.mem_write = bus32.out_mem_write;
    b.illegal   = bus32.out_illegal;
    b.rs1_value = bus32.out_rs1_value;
    b.rs2_value = bus32.out_rs2_value;
    b.imm       = bus32.out_imm;
    return b;
  endfunction

  function automatic string bundleStr(bundle_t b);
    return $sformatf("pc=%h op=%h f3=%0d f7=%h sub=%0d rd=%0d rdw=%0d mr=%0d mw=%0d ill=%0d rs1=%h rs2=%h imm=%h",
                     b.pc, b.opcode, b.funct3, b.funct7, b.sub_sra, b.rd, b.rd_write,
                     b.mem_read, b.mem_write, b.illegal, b.rs1_value, b.rs2_value, b.imm);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual %h required %h", name, actual, required);
    end
  endtask

  task automatic checkBundle(input string name, input bundle_t actual, input bundle_t required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual {%s} required {%s}", name, bundleStr(actual), bundleStr(required));
    end
  endtask

  // Present one instruction, push its expected bundle once the stage takes it.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input bundle_t exp, output int waited);
    bit accepted;
    accepted = 1'b0;
    waited = 0;
    bus32.in_instr = instr;
    bus32.in_pc    = pc;
    bus32.in_valid = 1'b1;
    for (int k = 0; k <= 20 && !accepted; k++) begin
      @(negedge clk);
      if (bus32.in_ready) begin
        accepted = 1'b1;
        sb.push_back(exp);
      end else begin
        waited++;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual in_ready=0 required acceptance pc=%h", pc);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.wb_en    = 1'b0;
  endtask

  task automatic wbWrite(input logic [4:0] rd, input logic [31:0] data);
    bus32.wb_en   = 1'b1;
    bus32.wb_rd   = rd;
    bus32.wb_data = data;
    @(posedge clk); #1;
    bus32.wb_en   = 1'b0;
  endtask

  // Scoreboard: compare each bundle as it transfers; a flushed bundle is dropped.
  always @(negedge clk) begin
    if (!reset && bus32.out_valid) begin
      if (bus32.flush) begin
        if (sb.size() > 0) mon_exp = sb.pop_front();
      end else if (bus32.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bundle actual {%s} required none", bundleStr(getBundle()));
        end else begin
          mon_exp = sb.pop_front();
          checkBundle("scoreboard", getBundle(), mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual timeout required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    int w;
    bundle_t e_add1, e_add2, e_lw, e_add4, e_hold, e_beq, e_lw2, e_add5;

    vecs[0]  = '{32'hFFF08413, 32'h300, mk(32'h300, 7'h13, 0, 0,    0, 8,  1, 0, 0, 0, 32'h100, 0,     32'hFFFFFFFF)};
    vecs[1]  = '{32'h40315493, 32'h304, mk(32'h304, 7'h13, 5, 7'h20, 1, 9,  1, 0, 0, 0, 32'h22,  0,     32'h403)};
    vecs[2]  = '{32'h40208533, 32'h308, mk(32'h308, 7'h33, 0, 7'h20, 1, 10, 1, 0, 0, 0, 32'h100, 32'h22, 0)};
    vecs[3]  = '{32'hFE20AE23, 32'h30C, mk(32'h30C, 7'h23, 2, 0,    0, 0,  0, 0, 1, 0, 32'h100, 32'h22, 32'hFFFFFFFC)};
    vecs[4]  = '{32'h123455B7, 32'h310, mk(32'h310, 7'h37, 5, 0,    0, 11, 1, 0, 0, 0, 0,       0,     32'h12345000)};
    vecs[5]  = '{32'h0100006F, 32'h314, mk(32'h314, 7'h6F, 0, 0,    0, 0,  0, 0, 0, 0, 0,       0,     32'h10)};
    vecs[6]  = '{32'hFFDFF0EF, 32'h318, mk(32'h318, 7'h6F, 7, 0,    0, 1,  1, 0, 0, 0, 0,       0,     32'hFFFFFFFC)};
    vecs[7]  = '{32'h00000013, 32'h31C, mk(32'h31C, 7'h13, 0, 0,    0, 0,  0, 0, 0, 0, 0,       0,     0)};
    vecs[8]  = '{32'h0000007F, 32'h320, mk(32'h320, 7'h7F, 0, 0,    0, 0,  0, 0, 0, 1, 0,       0,     0)};
    vecs[9]  = '{32'h00419613, 32'h324, mk(32'h324, 7'h13, 1, 0,    0, 12, 1, 0, 0, 0, 32'h33,  0,     32'h4)};
    vecs[10] = '{32'h7FF08693, 32'h328, mk(32'h328, 7'h13, 0, 0,    0, 13, 1, 0, 0, 0, 32'h100, 0,     32'h7FF)};
    vecs[11] = '{32'h00209463, 32'h32C, mk(32'h32C, 7'h63, 1, 0,    0, 0,  0, 0, 0, 0, 32'h100, 32'h22, 32'h8)};

    e_add1 = mk(32'h100, 7'h33, 0, 0, 0, 7, 1, 0, 0, 0, 0,        0,       0);
    e_add2 = mk(32'h104, 7'h33, 0, 0, 0, 7, 1, 0, 0, 0, 32'h1234, 32'hA,   0);
    e_lw   = mk(32'h400, 7'h03, 2, 0, 0, 3, 1, 1, 0, 0, 32'h100,  0,       0);
    e_add4 = mk(32'h404, 7'h33, 0, 0, 0, 4, 1, 0, 0, 0, 32'h33,   32'h22,  0);
    e_hold = mk(32'h500, 7'h33, 0, 0, 0, 7, 1, 0, 0, 0, 32'h1234, 32'hA,   0);
    e_beq  = mk(32'h600, 7'h63, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0,       32'hFFFFFFF8);
    e_lw2  = mk(32'h700, 7'h03, 2, 0, 0, 3, 1, 1, 0, 0, 32'h100,  0,       0);
    e_add5 = mk(32'h704, 7'h33, 0, 0, 0, 4, 1, 0, 0, 0, 32'h33,   32'h22,  0);

    reset = 1'b1;
    bus32.flush = 0; bus32.in_valid = 0; bus32.in_instr = 0; bus32.in_pc = 0;
    bus32.wb_en = 0; bus32.wb_rd = 0; bus32.wb_data = 0; bus32.out_ready = 1;
    bus16.flush = 0; bus16.in_valid = 0; bus16.in_instr = 0; bus16.in_pc = 0;
    bus16.wb_en = 0; bus16.wb_rd = 0; bus16.wb_data = 0; bus16.out_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_in_ready", bus32.in_ready, 0);
    checkOutput("reset_out_valid", bus32.out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] reset after random register writes");
    wbWrite(5'd5, $urandom | 32'h1);
    wbWrite(5'd6, $urandom | 32'h1);
    for (int i = 0; i < 4; i++) wbWrite(5'($urandom_range(1, 31)), $urandom);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("release_out_valid", bus32.out_valid, 0);
    checkOutput("release_in_ready", bus32.in_ready, 1);
    checkBundle("release_fields", getBundle(), '0);
    @(posedge clk); #1;
    applyStimulus(32'h006283B3, 32'h100, e_add1, w);
    checkOutput("t1_wait", w, 0);

    $display("[TB] writeback bypass");
    wbWrite(5'd5, 32'h1234);
    bus32.wb_en = 1'b1; bus32.wb_rd = 5'd6; bus32.wb_data = 32'hA;
    applyStimulus(32'h006283B3, 32'h104, e_add2, w);
    checkOutput("t2_wait", w, 0);
    @(negedge clk);
    checkOutput("t2_latency_valid", bus32.out_valid, 1);
    @(posedge clk); #1;

    wbWrite(5'd1, 32'h100);
    wbWrite(5'd2, 32'h22);
    wbWrite(5'd3, 32'h33);

    $display("[TB] instruction table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].exp, w);
      checkOutput($sformatf("vec%0d_wait", i), w, 0);
    end

    $display("[TB] load-use bubble");
    applyStimulus(32'h0000A183, 32'h400, e_lw, w);
    bus32.in_instr = 32'h00218233; bus32.in_pc = 32'h404; bus32.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("t3_c1_out_valid", bus32.out_valid, 1);
    checkOutput("t3_c1_in_ready", bus32.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t3_c2_out_valid", bus32.out_valid, 0);
    checkOutput("t3_c2_in_ready", bus32.in_ready, 1);
    if (bus32.in_ready) sb.push_back(e_add4);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t3_c3_out_valid", bus32.out_valid, 1);
    @(posedge clk); #1;

    $display("[TB] downstream stall hold");
    bus32.out_ready = 1'b0;
    applyStimulus(32'h006283B3, 32'h500, e_hold, w);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus32.wb_en = 1'b1; bus32.wb_rd = 5'd5; bus32.wb_data = 32'h9999;
      end else begin
        bus32.wb_en = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("t4_hold%0d_in_ready", c), bus32.in_ready, 0);
      checkBundle($sformatf("t4_hold%0d_bundle", c), getBundle(), e_hold);
      @(posedge clk); #1;
    end
    bus32.wb_en = 1'b0;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;

    $display("[TB] branch immediate and flush of held bundle");
    bus32.out_ready = 1'b0;
    applyStimulus(32'hFE000CE3, 32'h600, e_beq, w);
    @(negedge clk);
    checkBundle("t5_beq_held", getBundle(), e_beq);
    @(posedge clk); #1;
    bus32.flush = 1'b1;
    @(negedge clk);
    checkOutput("t5_flush_in_ready", bus32.in_ready, 0);
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    @(negedge clk);
    checkOutput("t5_flushed_valid", bus32.out_valid, 0);
    @(posedge clk); #1;

    $display("[TB] flush during load-use stall");
    applyStimulus(32'h0000A183, 32'h700, e_lw2, w);
    bus32.in_instr = 32'h00218233; bus32.in_pc = 32'h704; bus32.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("fh_stall_in_ready", bus32.in_ready, 0);
    @(posedge clk); #1;
    bus32.flush = 1'b1;
    @(negedge clk);
    checkOutput("fh_flush_in_ready", bus32.in_ready, 0);
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    @(negedge clk);
    checkOutput("fh_after_out_valid", bus32.out_valid, 0);
    checkOutput("fh_after_in_ready", bus32.in_ready, 1);
    if (bus32.in_ready) sb.push_back(e_add5);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("fh_dep_out_valid", bus32.out_valid, 1);
    @(posedge clk); #1;

    $display("[TB] 16-register configuration");
    bus16.in_instr = 32'h002088B3; bus16.in_pc = 32'h800; bus16.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("t6_in_ready", bus16.in_ready, 1);
    @(posedge clk); #1;
    bus16.in_instr = 32'h0000007F;
    @(negedge clk);
    checkOutput("t6_x17_valid", bus16.out_valid, 1);
    checkOutput("t6_x17_illegal", bus16.out_illegal, 1);
    checkOutput("t6_x17_rd_write", bus16.out_rd_write, 0);
    checkOutput("t6_x17_mem", {bus16.out_mem_read, bus16.out_mem_write}, 0);
    @(posedge clk); #1;
    bus16.in_instr = 32'h006283B3;
    @(negedge clk);
    checkOutput("t6_op7f_illegal", bus16.out_illegal, 1);
    checkOutput("t6_op7f_opcode", bus16.out_opcode, 32'h7F);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_legal_illegal", bus16.out_illegal, 0);
    checkOutput("t6_legal_rd_write", bus16.out_rd_write, 1);
    checkOutput("t6_legal_rd", bus16.out_rd, 7);
    @(posedge clk); #1;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #1;
    checkOutput("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
